// File: rtl/rca_seq_add_ctrl.sv
// ---------------------------------------------------------------------------
// rca_seq_add_ctrl
//   Performs one WIDTH-bit addition as NSLICE = WIDTH/SLICE passes through a
//   single SLICE-bit ripple-carry slice. The carry between passes is held in
//   a register, so the longest combinational path is one slice, not WIDTH
//   bits. Used as the final carry-propagate stage behind the Wallace tree.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      a, b, cin are valid
//   in_ready   out  1      operands are accepted (IDLE)
//   a, b       in   WIDTH  addends
//   cin        in   1      carry into slice 0
//   out_valid  out  1      sum/cout are valid (DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  registered (a+b+cin) mod 2^WIDTH
//   cout       out  1      registered carry out of the top slice
//   busy       out  1      high in RUN and DONE
// ---------------------------------------------------------------------------

// One-bit full adder; the slice is a plain ripple chain of these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_seq_add_ctrl #(
    parameter int WIDTH = 128,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("rca_seq_add_ctrl: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Current slice operands and the ripple chain that adds them.
    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] rs;
    logic [SLICE:0]   rc;

    assign sa    = a_q[idx*SLICE +: SLICE];
    assign sb    = b_q[idx*SLICE +: SLICE];
    // The inter-slice carry enters only from the register, never from the
    // previous slice combinationally.
    assign rc[0] = carry;

    generate
        for (genvar i = 0; i < SLICE; i++) begin : g_fa
            full_adder u_fa (
                .a  (sa[i]),
                .b  (sb[i]),
                .ci (rc[i]),
                .s  (rs[i]),
                .co (rc[i+1])
            );
        end
    endgenerate

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // behaviour between idx, carry and sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum[idx*SLICE +: SLICE] <= rs;
                    carry                   <= rc[SLICE];
                    if (idx == IDXW'(NSLICE - 1)) begin
                        cout  <= rc[SLICE];
                        state <= S_DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    // Result holds until taken; no accept in the same cycle.
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rca_seq_add_ctrl
//   Self-checking bench for rca_seq_add_ctrl. Three instances share stimulus:
//   SLICE=16 (main), SLICE=128 and SLICE=4. Expected results come from a
//   129-bit reference sum kept in a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_rca_seq_add_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] a = '0;
    logic [127:0] b = '0;
    logic         cin = 1'b0;

    logic         m_in_ready, m_out_valid, m_cout, m_busy;
    logic [127:0] m_sum;
    logic         w_in_ready, w_out_valid, w_cout, w_busy;
    logic [127:0] w_sum;
    logic         n_in_ready, n_out_valid, n_cout, n_busy;
    logic [127:0] n_sum;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [128:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_seq_add_ctrl #(.WIDTH(128), .SLICE(16)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(m_out_valid), .out_ready(out_ready),
        .sum(m_sum), .cout(m_cout), .busy(m_busy)
    );

    rca_seq_add_ctrl #(.WIDTH(128), .SLICE(128)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(w_out_valid), .out_ready(out_ready),
        .sum(w_sum), .cout(w_cout), .busy(w_busy)
    );

    rca_seq_add_ctrl #(.WIDTH(128), .SLICE(4)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(n_out_valid), .out_ready(out_ready),
        .sum(n_sum), .cout(n_cout), .busy(n_busy)
    );

    function automatic logic [128:0] model(input logic [127:0] x, input logic [127:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {128'd0, c};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
    endtask

    // Present one operand set for exactly one edge on the main instance.
    task automatic issue(input logic [127:0] aa, input logic [127:0] bb, input logic cc);
        a = aa; b = bb; cin = cc; in_valid = 1'b1;
        check("accept_ready", m_in_ready, 1);
        exp_q.push_back(model(aa, bb, cc));
        tick();
        in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_main(input string tag, output int lat);
        for (int i = 0; i < 64 && !m_out_valid; i++) tick();
        lat = cyc - acc_cyc;
        check(tag, m_out_valid, 1);
    endtask

    task automatic take_result(input string tag);
        logic [128:0] e;
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
        check(tag, {m_cout, m_sum}, e);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, {m_in_ready, m_out_valid}, 2'b10);
    endtask

    initial begin
        int lat, lw, lm, ln, taken, accepted, guard;
        logic acc, take, prev_ov;
        logic [128:0] snap, e;

        // Reset state
        do_reset();
        check("rst_sum", m_sum, 0);
        check("rst_cout", m_cout, 0);
        check("rst_flags", {m_in_ready, m_out_valid, m_busy}, 3'b100);

        // 1: all-ones + 1 wraps to zero with carry out
        issue('1, 128'd1, 1'b0);
        check("t1_busy", m_busy, 1);
        wait_main("t1_valid", lat);
        check("t1_latency", lat, 8);
        take_result("t1_result");

        // 2 + 3: carry crossing slice 2 -> 3, then hold result in DONE
        issue(128'h0000_FFFF_FFFF_FFFF, 128'd1, 1'b0);
        wait_main("t2_valid", lat);
        check("t2_latency", lat, 8);
        check("t2_sum", {m_cout, m_sum}, {1'b0, 128'h1_0000_0000_0000});
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = rand128(); b = rand128(); cin = 1'b1;
            tick();
            check("t3_hold_sum", {m_cout, m_sum}, exp_q[0]);
            check("t3_hold_flags", {m_in_ready, m_out_valid}, 2'b01);
        end
        in_valid = 1'b0;
        take_result("t3_result");
        tick();
        check("t3_no_stray_op", m_busy, 0);

        // 4: reset in RUN at idx=4 discards the op
        issue(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h1111, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("t4_busy_before", m_busy, 1);
        rst = 1'b1;
        #1;
        check("t4_rst_sum", m_sum, 0);
        check("t4_rst_cout", m_cout, 0);
        check("t4_rst_flags", {m_out_valid, m_busy}, 2'b00);
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        issue(128'd5, 128'd7, 1'b1);
        wait_main("t4_valid", lat);
        check("t4_latency", lat, 8);
        check("t4_sum13", {m_cout, m_sum}, 129'd13);
        take_result("t4_result");

        // 6: SLICE=128 and SLICE=4 latency and top-bit carry
        do_reset();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) issue({1'b1, 127'd0}, {1'b1, 127'd0}, 1'b0);
            else        issue(rand128(), rand128(), 1'($urandom_range(0, 1)));
            lw = -1; lm = -1; ln = -1;
            for (int i = 0; i < 40 && (lw < 0 || lm < 0 || ln < 0); i++) begin
                tick();
                if (w_out_valid && lw < 0) lw = cyc - acc_cyc;
                if (m_out_valid && lm < 0) lm = cyc - acc_cyc;
                if (n_out_valid && ln < 0) ln = cyc - acc_cyc;
            end
            check("t6_lat_slice128", lw, 1);
            check("t6_lat_slice16", lm, 8);
            check("t6_lat_slice4", ln, 32);
            if (k == 0) check("t6_top_carry", exp_q[0], {1'b1, 128'd0});
            check("t6_sum_slice128", {w_cout, w_sum}, exp_q[0]);
            check("t6_sum_slice4", {n_cout, n_sum}, exp_q[0]);
            take_result("t6_sum_slice16");
        end

        // 5: 1000 back-to-back random ops with random out_ready
        do_reset();
        taken = 0; accepted = 0; guard = 0; prev_ov = 1'b0; e = '0;
        while (taken < 1000 && guard < 40000) begin
            a = rand128();
            b = ($urandom_range(0, 3) == 0) ? ~a : rand128();
            cin = 1'($urandom_range(0, 1));
            in_valid = (accepted < 1000);
            out_ready = 1'($urandom_range(0, 1));
            acc  = in_valid && m_in_ready;
            take = m_out_valid && out_ready;
            snap = {m_cout, m_sum};
            if (acc) e = model(a, b, cin);
            tick();
            guard++;
            if (acc) begin
                exp_q.push_back(e);
                acc_cyc = cyc;
                accepted++;
            end
            if (take) begin
                if (exp_q.size() == 0) check("rand_unexpected_out", snap, 'x);
                else check("rand_sum", snap, exp_q.pop_front());
                taken++;
            end
            if (m_out_valid && !prev_ov) check("rand_latency", cyc - acc_cyc, 8);
            prev_ov = m_out_valid;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("rand_completed", taken, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
